// File: rtl/hardware_transmitter.sv
// Serializer for the optical link: valid/ready word intake, optional alternating
// preamble per burst, then MSB-first bits, each held BIT_CYCLES clocks on dout.
module hardware_transmitter #(
    parameter int DATA_WIDTH    = 8,
    parameter int BIT_CYCLES    = 10,
    parameter int PREAMBLE_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  dout,
    output logic                  busy
);

    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int PRE_W = (PREAMBLE_BITS > 1) ? $clog2(PREAMBLE_BITS) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'((PREAMBLE_BITS > 0) ? (PREAMBLE_BITS - 1) : 0);
    localparam bit               HAS_PRE  = (PREAMBLE_BITS > 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } state_t;

    // Preamble bit k is 1 for even k and 0 for odd k.
    function automatic logic pre_level(input logic [PRE_W-1:0] k);
        return ~k[0];
    endfunction

    state_t                  state_r, state_s;
    logic [CYC_W-1:0]        cyc_r, cyc_s;
    logic [BIT_W-1:0]        bit_idx_r, bit_idx_s;
    logic [PRE_W-1:0]        pre_idx_r, pre_idx_s;
    logic [DATA_WIDTH-1:0]   shift_r, shift_s;
    logic [DATA_WIDTH-1:0]   shifted_s;
    logic                    dout_r, dout_s;
    logic                    s_ready_s;
    logic                    accept_s;
    logic                    boundary_s;

    assign shifted_s  = shift_r << 1'b1;
    assign boundary_s = (cyc_r == CYC_LAST);

    // Ready when idle, or on the very last cycle of the final data bit.
    always_comb begin
        s_ready_s = 1'b0;
        if (state_r == ST_IDLE) begin
            s_ready_s = 1'b1;
        end else if ((state_r == ST_DATA) && (bit_idx_r == BIT_LAST) && boundary_s) begin
            s_ready_s = 1'b1;
        end else begin
            s_ready_s = 1'b0;
        end
    end

    assign accept_s = s_valid && s_ready_s;

    // Next-state, counter, shift register and line-level computation.
    always_comb begin
        state_s   = state_r;
        cyc_s     = cyc_r;
        bit_idx_s = bit_idx_r;
        pre_idx_s = pre_idx_r;
        shift_s   = shift_r;
        dout_s    = dout_r;
        case (state_r)
            ST_IDLE: begin
                cyc_s  = '0;
                dout_s = 1'b0;
                if (accept_s) begin
                    shift_s   = s_data;
                    bit_idx_s = '0;
                    pre_idx_s = '0;
                    if (HAS_PRE) begin
                        state_s = ST_PREAMBLE;
                        dout_s  = 1'b1;
                    end else begin
                        state_s = ST_DATA;
                        dout_s  = s_data[DATA_WIDTH-1];
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (boundary_s) begin
                    cyc_s = '0;
                    if (pre_idx_r == PRE_LAST) begin
                        state_s   = ST_DATA;
                        bit_idx_s = '0;
                        dout_s    = shift_r[DATA_WIDTH-1];
                    end else begin
                        pre_idx_s = pre_idx_r + 1'b1;
                        dout_s    = pre_level(pre_idx_r + 1'b1);
                    end
                end else begin
                    cyc_s = cyc_r + 1'b1;
                end
            end
            ST_DATA: begin
                if (boundary_s) begin
                    cyc_s = '0;
                    if (bit_idx_r == BIT_LAST) begin
                        bit_idx_s = '0;
                        if (accept_s) begin
                            // Back-to-back word: no preamble, no gap.
                            shift_s = s_data;
                            dout_s  = s_data[DATA_WIDTH-1];
                        end else begin
                            state_s = ST_IDLE;
                            shift_s = '0;
                            dout_s  = 1'b0;
                        end
                    end else begin
                        bit_idx_s = bit_idx_r + 1'b1;
                        shift_s   = shifted_s;
                        dout_s    = shifted_s[DATA_WIDTH-1];
                    end
                end else begin
                    cyc_s = cyc_r + 1'b1;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cyc_s     = '0;
                bit_idx_s = '0;
                pre_idx_s = '0;
                shift_s   = '0;
                dout_s    = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset abandons any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cyc_r     <= '0;
            bit_idx_r <= '0;
            pre_idx_r <= '0;
            shift_r   <= '0;
            dout_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cyc_r     <= cyc_s;
            bit_idx_r <= bit_idx_s;
            pre_idx_r <= pre_idx_s;
            shift_r   <= shift_s;
            dout_r    <= dout_s;
        end
    end

    assign s_ready = s_ready_s;
    assign dout    = dout_r;
    assign busy    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_hardware_transmitter.sv
// Bench for hardware_transmitter: per-cycle line model built from queued bit levels,
// plus directed literal checks; two instances cover default and no-preamble configs.
module tb_hardware_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic       r0, r1, o0, o1, b0, b1;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Expected line level for the current and every upcoming cycle of the burst.
    int q0[$];
    int q1[$];
    int e0, e1;

    always #5 clk = ~clk;

    hardware_transmitter #(.DATA_WIDTH(8), .BIT_CYCLES(10), .PREAMBLE_BITS(4)) dut0 (
        .clk(clk), .rst(rst), .s_data(d0), .s_valid(v0), .s_ready(r0), .dout(o0), .busy(b0)
    );

    hardware_transmitter #(.DATA_WIDTH(8), .BIT_CYCLES(9), .PREAMBLE_BITS(0)) dut1 (
        .clk(clk), .rst(rst), .s_data(d1), .s_valid(v1), .s_ready(r1), .dout(o1), .busy(b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model for instance 0: ready when at most the final cycle remains.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q0.delete();
        end else begin
            bit rdy, idle;
            rdy  = (q0.size() <= 1);
            idle = (q0.size() == 0);
            if (q0.size() > 0) void'(q0.pop_front());
            if (v0 && rdy) begin
                if (idle)
                    for (int k = 0; k < 4; k++)
                        for (int c = 0; c < 10; c++) q0.push_back((k % 2 == 0) ? 1 : 0);
                for (int i = 0; i < 8; i++)
                    for (int c = 0; c < 10; c++) q0.push_back(int'(d0[7-i]));
            end
        end
    end

    // Model for instance 1: no preamble, 9 cycles per bit.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q1.delete();
        end else begin
            bit rdy;
            rdy = (q1.size() <= 1);
            if (q1.size() > 0) void'(q1.pop_front());
            if (v1 && rdy)
                for (int i = 0; i < 8; i++)
                    for (int c = 0; c < 9; c++) q1.push_back(int'(d1[7-i]));
        end
    end

    // Per-cycle comparison of both instances against the models.
    always @(negedge clk) begin
        if (chk_en && rst) begin
            e0 = (q0.size() > 0) ? q0[0] : 0;
            e1 = (q1.size() > 0) ? q1[0] : 0;
            check("m0_dout",  32'(o0), e0);
            check("m0_busy",  32'(b0), (q0.size() > 0) ? 1 : 0);
            check("m0_ready", 32'(r0), (q0.size() <= 1) ? 1 : 0);
            check("m1_dout",  32'(o1), e1);
            check("m1_busy",  32'(b1), (q1.size() > 0) ? 1 : 0);
            check("m1_ready", 32'(r1), (q1.size() <= 1) ? 1 : 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] lit;
        logic [7:0]  w;
        int busyc, rdyc, highc, ready_j;
        bit sent;

        // Reset asserted mid-cycle takes effect before the next edge.
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_dout0",  32'(o0), 0);
        check("rst_busy0",  32'(b0), 0);
        check("rst_ready0", 32'(r0), 1);
        check("rst_dout1",  32'(o1), 0);
        check("rst_ready1", 32'(r1), 1);
        @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b1;
        highc  = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (o0 !== 1'b0) highc++;
        end
        check("idle_dout_high_cycles", highc, 0);

        // Single word A5 with preamble.
        v0 = 1'b1; d0 = 8'hA5;
        @(negedge clk);
        v0 = 1'b0;
        lit = 12'b1010_1010_0101;
        busyc = 0; rdyc = 0;
        for (int j = 0; j < 130; j++) begin
            if (b0) busyc++;
            if (j < 120 && r0) rdyc++;
            if (j % 10 == 5) check("a5_bit", 32'(o0), (j / 10 < 12) ? 32'(lit[11 - j / 10]) : 32'd0);
            if (j == 119) check("a5_ready_last", 32'(r0), 1);
            if (j == 120) check("a5_done_busy", 32'(b0), 0);
            @(negedge clk);
        end
        check("a5_busy_cycles", busyc, 120);
        check("a5_ready_cycles", rdyc, 1);

        // Back-to-back FF then 00, second word offered as soon as ready.
        v0 = 1'b1; d0 = 8'hFF;
        @(negedge clk);
        v0 = 1'b0;
        sent = 1'b0; busyc = 0; ready_j = -1;
        for (int j = 0; j < 220; j++) begin
            if (b0) busyc++;
            if (j == 35)  check("b2b_pre3", 32'(o0), 0);
            if (j == 40)  check("b2b_ff_first", 32'(o0), 1);
            if (j == 119) check("b2b_ff_last", 32'(o0), 1);
            if (j == 120) check("b2b_00_first", 32'(o0), 0);
            if (j == 120) check("b2b_no_gap_busy", 32'(b0), 1);
            if (!sent && j > 0 && r0) begin
                v0 = 1'b1; d0 = 8'h00; sent = 1'b1; ready_j = j;
            end else begin
                v0 = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_ready_cycle", ready_j, 119);
        check("b2b_busy_cycles", busyc, 200);

        // Backpressure: valid held, data churning every cycle.
        for (int j = 0; j < 300; j++) begin
            v0 = 1'b1;
            d0 = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        v0 = 1'b0;
        repeat (200) @(negedge clk);
        check("bp_drained_busy", 32'(b0), 0);

        // Abort during data bit 3 of 3C, then a full burst of 81.
        v0 = 1'b1; d0 = 8'h3C;
        @(negedge clk);
        v0 = 1'b0;
        repeat (75) @(negedge clk);
        check("abort_bit3_level", 32'(o0), 1);
        rst = 1'b0;
        #1;
        check("abort_dout",  32'(o0), 0);
        check("abort_busy",  32'(b0), 0);
        check("abort_ready", 32'(r0), 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        v0 = 1'b1; d0 = 8'h81;
        @(negedge clk);
        v0 = 1'b0;
        lit = 12'b1010_1000_0001;
        for (int j = 0; j < 125; j++) begin
            if (j % 10 == 5) check("x81_bit", 32'(o0), (j / 10 < 12) ? 32'(lit[11 - j / 10]) : 32'd0);
            @(negedge clk);
        end

        // No-preamble instance, 9 cycles per bit, word 01.
        v1 = 1'b1; d1 = 8'h01;
        @(negedge clk);
        v1 = 1'b0;
        w = 8'h01;
        busyc = 0;
        for (int j = 0; j < 80; j++) begin
            if (b1) busyc++;
            if (j == 0) check("np_first_bit", 32'(o1), 0);
            if (j % 9 == 4 && j / 9 < 8) check("np_bit", 32'(o1), 32'(w[7 - j / 9]));
            if (j == 63) check("np_last_bit_start", 32'(o1), 1);
            if (j == 72) check("np_done_dout", 32'(o1), 0);
            @(negedge clk);
        end
        check("np_busy_cycles", busyc, 72);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hardware_transmitter.md
Name: hardware_transmitter

Overview:
- Transmit-side serializer for the optical link. It accepts parallel words through a valid/ready handshake and drives them MSB-first onto a single line.
- Each bit is held for BIT_CYCLES system clocks (60 MHz clk, about 6 Mbit/s line rate), so the oversampling receiver sees at least 8 identical samples per bit.
- Each burst starts with an alternating preamble so the far end can lock onto bit boundaries.

Parameters:
- DATA_WIDTH, 8: bits per word.
- BIT_CYCLES, 10: clk cycles each line bit is held. Legal range is 9 to 512.
- PREAMBLE_BITS, 4: alternating 1/0 bits sent before the first word of a burst. A value of 0 disables the preamble.

Ports:
- clk  input  1  system clock, 60 MHz.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- s_data  input  DATA_WIDTH  word to transmit.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial line output, registered.
- busy  output  1  high while in PREAMBLE or DATA.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately):
  - state=IDLE, dout=0, busy=0, s_ready=1.
  - Shift register and counters are cleared.
  - A word in flight is abandoned. No partial completion.
- Handshake:
  - A word is accepted on a rising edge where s_valid and s_ready are both 1.
  - s_data is captured into the shift register on that edge.
  - s_ready is combinational: (state==IDLE) OR (state==DATA AND bit_idx==DATA_WIDTH-1 AND cyc==BIT_CYCLES-1).
  - s_valid held while s_ready=0 has no effect. Changes to s_data while not ready are ignored.
- State machine:
  - IDLE: dout=0.
    - On accept with PREAMBLE_BITS>0: go to PREAMBLE, pre_idx=0, dout<=1.
    - On accept with PREAMBLE_BITS=0: go to DATA, bit_idx=0, dout<=s_data[MSB].
  - PREAMBLE: bit k drives 1 for even k and 0 for odd k. Each bit lasts exactly BIT_CYCLES cycles.
    - After the last preamble bit's final cycle: go to DATA, dout<=word[MSB].
  - DATA: bit i drives word[DATA_WIDTH-1-i] for exactly BIT_CYCLES cycles.
    - Final cycle of the last bit, with an accept: stay in DATA, bit_idx=0, dout<=new word MSB. No preamble and no gap between back-to-back words.
    - Final cycle of the last bit, without an accept: go to IDLE, dout<=0.
- Timing:
  - dout changes only on bit boundaries.
  - First line bit appears on the clock edge that accepts the word (latency 1 cycle from accept to line).
  - Burst length is (PREAMBLE_BITS + n*DATA_WIDTH)*BIT_CYCLES cycles for n back-to-back words.
- Counters:
  - cyc counts 0..BIT_CYCLES-1 and wraps to 0 at each bit boundary. Width is clog2(BIT_CYCLES).
  - bit_idx counts 0..DATA_WIDTH-1. pre_idx counts 0..PREAMBLE_BITS-1. Neither overflows.
- busy = (state != IDLE). It deasserts on the same edge dout returns to 0.
- No output is ever X after reset.

Test Plan:
- Reset: assert rst=0 mid-cycle -> dout=0, busy=0, s_ready=1 before the next edge. Release rst, hold s_valid=0 for 100 cycles -> dout stays 0.
- Single word with defaults, s_data=8'hA5 -> dout runs 1,0,1,0 (preamble), then 1,0,1,0,0,1,0,1. Each level is held exactly 10 cycles. busy is high for 120 cycles. s_ready=1 only in cycle 120. dout=0 and busy=0 afterwards.
- Back-to-back 8'hFF then 8'h00, second word presented in the final cycle -> 40 preamble cycles, then 80 cycles of 1, then 80 cycles of 0. No preamble and no idle cycle between the words. Total busy is 200 cycles.
- Backpressure: hold s_valid=1 with s_data changing every cycle while busy -> no accept until s_ready=1. The transmitted word equals s_data on the accept edge only.
- Abort: assert rst=0 during data bit 3 of 8'h3C -> dout=0 immediately. After release, send 8'h81 -> the full preamble is re-sent, then 1,0,0,0,0,0,0,1.
- Config PREAMBLE_BITS=0, BIT_CYCLES=9, s_data=8'h01 -> seven 0-bits then one 1-bit, each 9 cycles, starting on the accept edge. busy lasts 72 cycles.
